sfx_arbiter: RTL and testbench

Shares the single audio_note tone generator between N sound requesters: background music, laser shot, explosion, UI beep, and so on. Requesters present a frequency word and a duration. The arbiter grants by fixed priority, times playback, inserts a short silence gap between sounds, and drives one frequency word into audio_note. A higher-priority sound preempts a lower-priority one that is already playing.

---
 rtl/sfx_arbiter.sv | 176 +++++++++++++++++
 tb/tb_sfx_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sfx_arbiter.sv
// sfx_arbiter: shares one tone generator between N_REQ sound requesters.
// Grants go by fixed priority, with index 0 the highest. The arbiter times
// each sound, adds a silence gap after a sound ends on its own, and lets a
// higher-priority request displace the sound that is playing.
module sfx_arbiter #(
  parameter int N_REQ      = 4,
  parameter int FREQ_W     = 24,
  parameter int DUR_W      = 24,
  parameter int GAP_CYCLES = 1200,
  localparam int OW        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [N_REQ-1:0]          i_req,
  input  logic [N_REQ*FREQ_W-1:0]   i_freq,
  input  logic [N_REQ*DUR_W-1:0]    i_dur,
  input  logic                      i_mute,
  output logic [FREQ_W-1:0]         o_freq,
  output logic [N_REQ-1:0]          o_ack,
  output logic [N_REQ-1:0]          o_done,
  output logic                      o_preempt,
  output logic                      o_busy,
  output logic [OW-1:0]             o_owner
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // The counter is loaded with (cycles - 1), so zero marks the last cycle of a phase.
  localparam logic [DUR_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? DUR_W'(GAP_CYCLES - 1) : '0;

  state_t              state_reg, state_next;
  logic [DUR_W-1:0]    cnt_reg, cnt_next;
  logic [OW-1:0]       owner_reg, owner_next;
  logic [FREQ_W-1:0]   tone_reg, tone_next;
  logic [FREQ_W-1:0]   freq_reg, freq_next;
  logic [N_REQ-1:0]    ack_reg, ack_next;
  logic [N_REQ-1:0]    done_reg, done_next;
  logic                preempt_reg, preempt_next;
  logic                busy_reg, busy_next;

  logic [FREQ_W-1:0]   freq_word [N_REQ];
  logic [DUR_W-1:0]    dur_word  [N_REQ];
  logic                win_any;
  logic [OW-1:0]       win_idx;
  logic [N_REQ-1:0]    win_onehot;
  logic [N_REQ-1:0]    owner_onehot;
  logic [DUR_W-1:0]    win_dur;
  logic [DUR_W-1:0]    win_load;
  logic                grant;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign freq_word[gi] = i_freq[gi*FREQ_W +: FREQ_W];
      assign dur_word[gi]  = i_dur[gi*DUR_W +: DUR_W];
    end
  endgenerate

  // Find the lowest-index active request. A zero duration plays for one cycle.
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (i_req[k]) begin
        win_any = 1'b1;
        win_idx = OW'(k);
      end
    end
    win_dur    = dur_word[win_idx];
    win_load   = (win_dur == '0) ? '0 : win_dur - DUR_W'(1);
    win_onehot = '0;
    win_onehot[win_idx] = 1'b1;
    owner_onehot = '0;
    owner_onehot[owner_reg] = 1'b1;
  end

  // Compute the next state and the registered outputs. A preemption is checked
  // before completion, so a higher-priority request that arrives in the last
  // tone cycle wins.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    owner_next   = owner_reg;
    tone_next    = tone_reg;
    ack_next     = '0;
    done_next    = '0;
    preempt_next = 1'b0;
    grant        = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        grant = win_any;
      end
      ST_PLAY: begin
        if (win_any && (win_idx < owner_reg)) begin
          grant        = 1'b1;
          preempt_next = 1'b1;
        end else if (cnt_reg != '0) begin
          cnt_next = cnt_reg - DUR_W'(1);
        end else begin
          done_next = owner_onehot;
          if (GAP_CYCLES > 0) begin
            state_next = ST_GAP;
            cnt_next   = GAP_LOAD;
          end else begin
            state_next = ST_IDLE;
            cnt_next   = '0;
          end
        end
      end
      ST_GAP: begin
        // A higher-priority request ends the gap early. On the last gap cycle,
        // any pending request is granted without passing through IDLE.
        if (win_any && ((win_idx < owner_reg) || (cnt_reg == '0))) begin
          grant = 1'b1;
        end else if (cnt_reg != '0) begin
          cnt_next = cnt_reg - DUR_W'(1);
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase

    if (grant) begin
      state_next = ST_PLAY;
      cnt_next   = win_load;
      owner_next = win_idx;
      tone_next  = freq_word[win_idx];
      ack_next   = win_onehot;
    end

    freq_next = ((state_next == ST_PLAY) && !i_mute) ? tone_next : '0;
    busy_next = (state_next != ST_IDLE);
  end

  // Hold the state and the outputs in registers. Reset drops any sound that is in progress.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      owner_reg   <= '0;
      tone_reg    <= '0;
      freq_reg    <= '0;
      ack_reg     <= '0;
      done_reg    <= '0;
      preempt_reg <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      owner_reg   <= owner_next;
      tone_reg    <= tone_next;
      freq_reg    <= freq_next;
      ack_reg     <= ack_next;
      done_reg    <= done_next;
      preempt_reg <= preempt_next;
      busy_reg    <= busy_next;
    end
  end

  assign o_freq    = freq_reg;
  assign o_ack     = ack_reg;
  assign o_done    = done_reg;
  assign o_preempt = preempt_reg;
  assign o_busy    = busy_reg;
  assign o_owner   = owner_reg;

endmodule

// File: tb/tb_sfx_arbiter.sv
// tb_sfx_arbiter: directed scenarios with literal expectations, followed by random
// traffic. A deadline-based model of the arbiter checks the DUT on every cycle.
module tb_sfx_arbiter;
  localparam int N   = 4;
  localparam int FW  = 24;
  localparam int DW  = 24;
  localparam int GAP = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            i_rst = 1'b1;
  logic            i_mute = 1'b0;
  logic [N-1:0]    i_req = '0;
  logic [N*FW-1:0] i_freq = '0;
  logic [N*DW-1:0] i_dur = '0;
  logic [FW-1:0]   o_freq;
  logic [N-1:0]    o_ack, o_done;
  logic            o_preempt, o_busy;
  logic [1:0]      o_owner;

  sfx_arbiter #(.N_REQ(N), .FREQ_W(FW), .DUR_W(DW), .GAP_CYCLES(GAP)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_req(i_req), .i_freq(i_freq), .i_dur(i_dur),
    .i_mute(i_mute), .o_freq(o_freq), .o_ack(o_ack), .o_done(o_done),
    .o_preempt(o_preempt), .o_busy(o_busy), .o_owner(o_owner)
  );

  int total = 0;
  int bad = 0;
  bit check_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at t=%0t", nm, got, want, $time);
    end
  endtask

  // Reference model. Each sound is described by absolute deadlines: the last
  // tone cycle and the last silence cycle, counted in cycles since time zero.
  longint           n_cyc = 0;
  longint           tone_last = -1;
  longint           gap_last = -1;
  int               m_owner = 0;
  logic [FW-1:0]    m_freq = '0;
  logic [FW-1:0]    e_freq = '0;
  logic [N-1:0]     e_ack = '0, e_done = '0;
  logic             e_pre = 1'b0, e_busy = 1'b0;
  logic [1:0]       e_owner = '0;

  initial forever begin
    int lo;
    bit was_tone, was_gap, grant;
    longint d;
    @(posedge clk);
    n_cyc++;
    e_ack = '0; e_done = '0; e_pre = 1'b0;
    if (i_rst) begin
      tone_last = -1; gap_last = -1; m_owner = 0; m_freq = '0;
      e_freq = '0; e_busy = 1'b0; e_owner = '0;
    end else begin
      lo = -1;
      for (int k = N - 1; k >= 0; k--) if (i_req[k]) lo = k;
      was_tone = (n_cyc - 1) <= tone_last;
      was_gap  = !was_tone && ((n_cyc - 1) <= gap_last);
      grant = 1'b0;
      if (was_tone) begin
        if (lo >= 0 && lo < m_owner) begin grant = 1'b1; e_pre = 1'b1; end
        else if ((n_cyc - 1) == tone_last) e_done[m_owner] = 1'b1;
      end else if (was_gap) begin
        if (lo >= 0 && (lo < m_owner || (n_cyc - 1) == gap_last)) grant = 1'b1;
      end else if (lo >= 0) begin
        grant = 1'b1;
      end
      if (grant) begin
        d = longint'(i_dur[lo*DW +: DW]);
        if (d == 0) d = 1;
        tone_last = n_cyc + d - 1;
        gap_last  = tone_last + GAP;
        m_owner   = lo;
        m_freq    = i_freq[lo*FW +: FW];
        e_ack[lo] = 1'b1;
      end
      e_busy  = (n_cyc <= gap_last);
      e_freq  = ((n_cyc <= tone_last) && !i_mute) ? m_freq : '0;
      e_owner = 2'(m_owner);
    end
  end

  // Compare the DUT with the model on every falling edge.
  initial forever begin
    @(negedge clk);
    if (check_en) begin
      chk("o_freq", 64'(o_freq), 64'(e_freq));
      chk("o_ack", 64'(o_ack), 64'(e_ack));
      chk("o_done", 64'(o_done), 64'(e_done));
      chk("o_preempt", 64'(o_preempt), 64'(e_pre));
      chk("o_busy", 64'(o_busy), 64'(e_busy));
      chk("o_owner", 64'(o_owner), 64'(e_owner));
    end
  end

  // Advance to the next falling edge. A requester drops its request once it sees its own ack.
  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < N; k++) if (o_ack[k] === 1'b1) i_req[k] = 1'b0;
  endtask

  task automatic set_req(input int k, input int f, input int d);
    i_req[k] = 1'b1;
    i_freq[k*FW +: FW] = FW'(f);
    i_dur[k*DW +: DW]  = DW'(d);
  endtask

  int c_tone, c_done, c_gap, c_x, w, done_at;

  initial begin
    tick(); tick();
    check_en = 1'b1;
    chk("reset_busy", 64'(o_busy), 0);
    chk("reset_freq", 64'(o_freq), 0);
    chk("reset_owner", 64'(o_owner), 0);
    i_rst = 1'b0;

    // A single request: 10 tone cycles, then 4 silent gap cycles.
    tick(); set_req(2, 440, 10);
    tick();
    chk("t1_ack", 64'(o_ack), 4);
    c_tone = (o_freq == 440) ? 1 : 0; c_done = 0; c_gap = 0;
    repeat (20) begin
      tick();
      if (o_freq != 0) c_tone++;
      if (o_done == 4'b0100) c_done++;
      if (o_busy && o_freq == 0) c_gap++;
    end
    chk("t1_tone", 64'(c_tone), 10);
    chk("t1_done", 64'(c_done), 1);
    chk("t1_gap", 64'(c_gap), 4);
    chk("t1_idle", 64'(o_busy), 0);
    $display("T1 single: tone=%0d done=%0d gap=%0d", c_tone, c_done, c_gap);

    // Two requests in the same cycle: requester 1 goes first, then requester 3 after the gap.
    tick(); set_req(1, 1111, 3); set_req(3, 3333, 2);
    tick();
    chk("t2_ack1", 64'(o_ack), 2);
    w = 0;
    while (o_ack[3] !== 1'b1 && w < 20) begin tick(); w++; end
    chk("t2_wait", 64'(w), 7);
    chk("t2_freq3", 64'(o_freq), 3333);
    $display("T2 tie: second grant after %0d cycles", w);
    repeat (12) tick();

    // Preemption: requester 0 displaces requester 3 partway through a long sound.
    tick(); set_req(3, 3000, 100);
    tick();
    repeat (18) tick();
    set_req(0, 880, 5);
    tick();
    chk("t3_pre", 64'(o_preempt), 1);
    chk("t3_ack", 64'(o_ack), 1);
    chk("t3_owner", 64'(o_owner), 0);
    c_tone = (o_freq == 880) ? 1 : 0; c_done = 0; c_gap = 0; c_x = 0;
    repeat (15) begin
      tick();
      if (o_freq == 880) c_tone++;
      if (o_done[3]) c_x++;
      if (o_done[0]) c_done++;
      if (o_freq == 3000) c_gap++;
    end
    chk("t3_tone", 64'(c_tone), 5);
    chk("t3_nodone3", 64'(c_x), 0);
    chk("t3_done0", 64'(c_done), 1);
    chk("t3_noresume", 64'(c_gap), 0);
    $display("T3 preempt: tone880=%0d done0=%0d", c_tone, c_done);

    // Preemption in the last tone cycle wins over completion.
    tick(); set_req(2, 2000, 6);
    tick();
    repeat (5) tick();
    chk("t4_last", 64'(o_freq), 2000);
    set_req(1, 1500, 3);
    tick();
    chk("t4_pre", 64'(o_preempt), 1);
    chk("t4_ack", 64'(o_ack), 2);
    chk("t4_nodone", 64'(o_done), 0);
    chk("t4_freq", 64'(o_freq), 1500);
    c_x = 0;
    repeat (12) begin tick(); if (o_done[2]) c_x++; end
    chk("t4_nodone2", 64'(c_x), 0);
    $display("T4 preempt at last cycle done");

    // A zero duration gives exactly one tone cycle.
    tick(); set_req(0, 77, 0);
    tick();
    chk("t5_ack", 64'(o_ack), 1);
    c_tone = (o_freq == 77) ? 1 : 0;
    repeat (8) begin tick(); if (o_freq == 77) c_tone++; end
    chk("t5_tone", 64'(c_tone), 1);
    $display("T5 zero dur: tone=%0d", c_tone);

    // Mute holds the output silent; ack and done timing are unchanged.
    tick(); set_req(2, 500, 4); i_mute = 1'b1;
    tick();
    chk("t6_ack", 64'(o_ack), 4);
    c_tone = (o_freq != 0) ? 1 : 0; done_at = -1;
    for (int j = 1; j <= 10; j++) begin
      tick();
      if (o_freq != 0) c_tone++;
      if (o_done == 4'b0100) done_at = j;
    end
    chk("t6_silent", 64'(c_tone), 0);
    chk("t6_done_at", 64'(done_at), 4);
    i_mute = 1'b0;
    $display("T6 mute: tone=%0d done_at=%0d", c_tone, done_at);
    repeat (4) tick();

    // Reset partway through a sound. A request already pending is granted right after release.
    tick(); set_req(1, 4321, 50);
    tick();
    repeat (6) tick();
    i_rst = 1'b1; set_req(3, 999, 7);
    tick();
    chk("t7_busy", 64'(o_busy), 0);
    chk("t7_freq", 64'(o_freq), 0);
    chk("t7_ack", 64'(o_ack), 0);
    chk("t7_done", 64'(o_done), 0);
    chk("t7_owner", 64'(o_owner), 0);
    i_rst = 1'b0;
    tick();
    chk("t7_regrant", 64'(o_ack), 8);
    chk("t7_freq3", 64'(o_freq), 999);
    c_x = 0;
    repeat (20) begin tick(); if (o_done[1]) c_x++; end
    chk("t7_nodone1", 64'(c_x), 0);
    $display("T7 reset mid-play done");

    // Random traffic checked by the model.
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int k = 0; k < N; k++) begin
        if (!i_req[k] && o_ack[k] !== 1'b1 && $urandom_range(0, 9) == 0) i_req[k] = 1'b1;
        i_freq[k*FW +: FW] = FW'($urandom);
        i_dur[k*DW +: DW]  = DW'($urandom_range(0, 12));
      end
      i_mute = ($urandom_range(0, 9) == 0);
      i_rst  = ($urandom_range(0, 299) == 0);
    end
    i_rst = 1'b0;
    repeat (3) tick();
    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
